// File: rtl/ad79x8_pkg.sv
// ad79x8_pkg: frame layout, control field positions and FSM states for the AD79x8 responder
package ad79x8_pkg;
  localparam int FRAME_BITS = 16;
  localparam int WRITE_BIT = 15;
  localparam int SEQ_BIT = 14;
  localparam int ADD_HI = 12;
  localparam int ADD_LO = 10;
  localparam int PM_HI = 9;
  localparam int PM_LO = 8;
  localparam int SHADOW_BIT = 7;
  localparam int RANGE_BIT = 5;
  localparam int CODING_BIT = 4;
  localparam int CTRL_LSB = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  // Outgoing frame: leading zero, echoed address, then the selected sample (MSB flipped for two's complement)
  function automatic logic [FRAME_BITS-1:0] build_tx(input logic [95:0] ch, input logic [2:0] add, input logic coding);
    logic [11:0] s;
    s = ch[add*12 +: 12];
    s[11] = s[11] ^ ~coding;
    return {1'b0, add, s};
  endfunction
endpackage

// File: rtl/ad79x8_responder_sync_edge.sv
// sync_edge: 2-flop synchronizer with rise/fall detect on the synchronized level
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign q = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/ad79x8_responder.sv
// ad79x8_responder: SPI target emulating an AD79x8 ADC (16-bit frames, control word in, sample out)
module ad79x8_responder
  import ad79x8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        serial_in,
  input  logic [95:0] ch_data,
  output logic        serial_out,
  output logic        serial_oe,
  output logic [11:0] ctrl,
  output logic        frame_done,
  output logic        frame_abort
);
  logic sclk_fall, cs_rise, cs_fall, din;
  logic sclk_level_unused, sclk_rise_unused, cs_level_unused, din_rise_unused, din_fall_unused;
  state_t state;
  logic [3:0] cnt;
  logic [FRAME_BITS-1:0] rx, tx, rx_n;
  sync_edge #(.RST_VAL(1'b1)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_level_unused), .rise(sclk_rise_unused), .fall(sclk_fall));
  sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst(rst), .d(cs), .q(cs_level_unused), .rise(cs_rise), .fall(cs_fall));
  sync_edge #(.RST_VAL(1'b0)) u_din (.clk(clk), .rst(rst), .d(serial_in), .q(din), .rise(din_rise_unused), .fall(din_fall_unused));
  assign rx_n = {rx[FRAME_BITS-2:0], din};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctrl <= '0;
      serial_out <= 1'b0;
      serial_oe <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      cnt <= '0;
      rx <= '0;
      tx <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      // cs rise takes priority over any sclk edge seen in the same cycle
      if (cs_rise) begin
        state <= IDLE;
        serial_oe <= 1'b0;
        serial_out <= 1'b0;
        frame_abort <= (state == SHIFT);
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            tx <= build_tx(ch_data, ctrl[ADD_HI-CTRL_LSB -: 3], ctrl[CODING_BIT-CTRL_LSB]);
            serial_out <= 1'b0;
            serial_oe <= 1'b1;
            cnt <= '0;
            state <= SHIFT;
          end
          SHIFT: if (sclk_fall) begin
            rx <= rx_n;
            tx <= tx << 1;
            cnt <= cnt + 4'd1;
            serial_out <= (cnt == 4'd15) ? 1'b0 : tx[FRAME_BITS-2];
            if (cnt == 4'd15) begin
              frame_done <= 1'b1;
              state <= HOLD;
              if (rx_n[WRITE_BIT]) ctrl <= rx_n[FRAME_BITS-1 -: 12];
            end
          end
          default: serial_out <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ad79x8_responder.sv
// tb_ad79x8_responder: directed frame-level checks of the AD79x8 responder
module tb_ad79x8_responder;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b1, cs = 1'b1, serial_in = 1'b0;
  logic [95:0] ch_data = '0;
  logic serial_out, serial_oe, frame_done, frame_abort;
  logic [11:0] ctrl;
  int checks = 0, errors = 0, done_cnt = 0, abort_cnt = 0;

  ad79x8_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .serial_in(serial_in), .ch_data(ch_data),
    .serial_out(serial_out), .serial_oe(serial_oe), .ctrl(ctrl),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] word, input int edges, input bit change_ch5,
                           output logic [15:0] dout, output logic tail_bad, output logic oe_bad);
    cs = 1'b0;
    wait_clk(8);
    dout = '0;
    tail_bad = 1'b0;
    oe_bad = 1'b0;
    for (int i = 0; i < edges; i++) begin
      serial_in = (i < 16) ? word[15-i] : 1'b0;
      if (change_ch5 && i == 4) ch_data[60 +: 12] = 12'h123;
      wait_clk(4);
      if (i < 16) dout[15-i] = serial_out;
      else if (serial_out !== 1'b0) tail_bad = 1'b1;
      if (serial_oe !== 1'b1) oe_bad = 1'b1;
      sclk = 1'b0;
      wait_clk(8);
      sclk = 1'b1;
      wait_clk(4);
    end
    if (edges >= 16 && serial_out !== 1'b0) tail_bad = 1'b1;
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset;
    wait_clk(3);
    checks++;
    if ({ctrl, serial_out, serial_oe, frame_done, frame_abort} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ctrl=%h so=%b oe=%b done=%b abort=%b, want all 0", ctrl, serial_out, serial_oe, frame_done, frame_abort);
    end
    rst = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_write_frame;
    logic [15:0] d;
    logic t, o;
    int d0;
    ch_data[60 +: 12] = 12'hABC;
    d0 = done_cnt;
    run_frame(16'h9710, 16, 1'b0, d, t, o);
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL write_done: got %0d pulses, want 1", done_cnt - d0); end
    checks++;
    if (ctrl !== 12'h971) begin errors++; $display("FAIL write_ctrl: got %h, want 971", ctrl); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL write_oe_during: oe dropped during frame"); end
    checks++;
    if (serial_oe !== 1'b0) begin errors++; $display("FAIL write_oe_after: got %b, want 0", serial_oe); end
    run_frame(16'h0000, 16, 1'b0, d, t, o);
    checks++;
    if (d !== 16'h5ABC) begin errors++; $display("FAIL readback_dout: got %h, want 5abc", d); end
  endtask

  task automatic test_coding;
    logic [15:0] d;
    logic t, o;
    run_frame(16'h9700, 16, 1'b0, d, t, o);
    checks++;
    if (ctrl !== 12'h970) begin errors++; $display("FAIL coding_ctrl: got %h, want 970", ctrl); end
    run_frame(16'h0000, 16, 1'b0, d, t, o);
    checks++;
    if (d !== 16'h52BC) begin errors++; $display("FAIL coding_dout: got %h, want 52bc", d); end
  endtask

  task automatic test_no_write;
    logic [15:0] d;
    logic t, o;
    int d0;
    d0 = done_cnt;
    run_frame(16'h1710, 16, 1'b0, d, t, o);
    checks++;
    if (ctrl !== 12'h970) begin errors++; $display("FAIL nowrite_ctrl: got %h, want 970", ctrl); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL nowrite_done: got %0d pulses, want 1", done_cnt - d0); end
  endtask

  task automatic test_abort;
    logic [15:0] d;
    logic t, o;
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    run_frame(16'h8000, 9, 1'b0, d, t, o);
    checks++;
    if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses, want 1", abort_cnt - a0); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses, want 0", done_cnt - d0); end
    checks++;
    if (ctrl !== 12'h970) begin errors++; $display("FAIL abort_ctrl: got %h, want 970", ctrl); end
    checks++;
    if (serial_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b, want 0", serial_oe); end
    run_frame(16'h9710, 16, 1'b0, d, t, o);
    checks++;
    if (ctrl !== 12'h971 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL after_abort: got ctrl=%h done=%0d, want ctrl=971 done=1", ctrl, done_cnt - d0);
    end
  endtask

  task automatic test_ch_sampled;
    logic [15:0] d;
    logic t, o;
    run_frame(16'h0000, 16, 1'b1, d, t, o);
    checks++;
    if (d !== 16'h5ABC) begin errors++; $display("FAIL ch_sampled: got %h, want 5abc", d); end
    ch_data[60 +: 12] = 12'hABC;
  endtask

  task automatic test_overrun;
    logic [15:0] d;
    logic t, o;
    int d0;
    d0 = done_cnt;
    run_frame(16'h1710, 20, 1'b0, d, t, o);
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL overrun_done: got %0d pulses, want 1", done_cnt - d0); end
    checks++;
    if (t !== 1'b0) begin errors++; $display("FAIL overrun_tail: serial_out got 1 after 16th edge, want 0"); end
    checks++;
    if (d !== 16'h5ABC || ctrl !== 12'h971) begin
      errors++;
      $display("FAIL overrun_data: got dout=%h ctrl=%h, want 5abc 971", d, ctrl);
    end
  endtask

  task automatic test_cs_high_sclk;
    int d0, a0;
    logic oe_seen;
    d0 = done_cnt;
    a0 = abort_cnt;
    oe_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b0;
      wait_clk(8);
      if (serial_oe !== 1'b0) oe_seen = 1'b1;
      sclk = 1'b1;
      wait_clk(8);
    end
    checks++;
    if (oe_seen || done_cnt !== d0 || abort_cnt !== a0 || ctrl !== 12'h971) begin
      errors++;
      $display("FAIL idle_sclk: got oe_seen=%b done=%0d abort=%0d ctrl=%h, want 0 0 0 971", oe_seen, done_cnt - d0, abort_cnt - a0, ctrl);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    logic t, o;
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    ch_data[0 +: 12] = 12'h345;
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      serial_in = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(8);
      sclk = 1'b1;
      wait_clk(4);
    end
    rst = 1'b1;
    wait_clk(2);
    checks++;
    if ({ctrl, serial_out, serial_oe, frame_done, frame_abort} !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctrl=%h so=%b oe=%b done=%b abort=%b, want all 0", ctrl, serial_out, serial_oe, frame_done, frame_abort);
    end
    cs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    checks++;
    if (done_cnt !== d0 || abort_cnt !== a0 || serial_oe !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pulses: got done=%0d abort=%0d oe=%b, want 0 0 0", done_cnt - d0, abort_cnt - a0, serial_oe);
    end
    run_frame(16'h0000, 16, 1'b0, d, t, o);
    checks++;
    if (d !== 16'h0B45) begin errors++; $display("FAIL midreset_dout: got %h, want 0b45", d); end
  endtask

  initial begin
    test_reset;
    test_write_frame;
    test_coding;
    test_no_write;
    test_abort;
    test_ch_sampled;
    test_overrun;
    test_cs_high_sclk;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ad79x8_responder.md
AD79X8_RESPONDER -- requirements
Module: ad79x8_responder

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: system clock, all logic on rising edge, at least 8x the sclk frequency.
REQ-002 The block SHALL provide port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 The block SHALL provide port sclk, input, 1 bit: SPI serial clock from the initiator, idle high, active on falling edge.
REQ-004 The block SHALL provide port cs, input, 1 bit: chip select, active low, frame delimiter.
REQ-005 The block SHALL provide port serial_in, input, 1 bit: DIN carrying the control word, MSB first.
REQ-006 The block SHALL provide port ch_data, input, 96 bits: eight 12-bit straight-binary samples, with channel n at bits [12n+11:12n].
REQ-007 The block SHALL provide port serial_out, output, 1 bit: DOUT, MSB first.
REQ-008 The block SHALL provide port serial_oe, output, 1 bit: DOUT drive enable, high only while a frame is active.
REQ-009 The block SHALL provide port ctrl, output, 12 bits: the current control register, holding frame bits [15:4].
REQ-010 The block SHALL provide port frame_done, output, 1 bit: 1-clk pulse after the 16th sclk falling edge.
REQ-011 The block SHALL provide port frame_abort, output, 1 bit: 1-clk pulse when cs rises before 16 edges.

Function
REQ-012 The block SHALL synchronize sclk, cs and serial_in with 2-flop synchronizers, then edge-detect them; event latency from pin to action is 3 clk.
REQ-013 The state machine SHALL have three states: IDLE, SHIFT and HOLD.
REQ-014 In IDLE, on a cs falling edge, the block SHALL:
- latch tx = {1'b0, ctrl ADD[2:0], sample};
- select sample = ch_data[ADD] when CODING=1, or the same value with its MSB inverted (two's complement) when CODING=0;
- clear the bit counter, set serial_out = tx[15], set serial_oe=1, and go to SHIFT.
REQ-015 In SHIFT, on each sclk falling edge, the block SHALL shift serial_in into rx LSB-first-in (MSB of frame ends at rx[15]), shift tx left with serial_out = next bit, and increment the 4-bit counter.
REQ-016 On the 16th falling edge (counter wrapping 15->0), the block SHALL pulse frame_done, load ctrl <= rx[15:4] including the new bit if WRITE (rx[15]) = 1 (otherwise ctrl is unchanged), and go to HOLD.
REQ-017 In HOLD, the block SHALL ignore further sclk edges and hold serial_out at 0.
REQ-018 A cs rising edge in any state SHALL force IDLE and serial_oe=0.
REQ-019 If a cs rising edge occurs in SHIFT, the block SHALL pulse frame_abort and leave ctrl unchanged.
REQ-020 If a cs rise and an sclk fall are detected in the same clk, the cs rise SHALL win and the sclk edge SHALL be discarded.
REQ-021 ch_data SHALL be sampled only at the cs falling edge; later changes SHALL NOT affect the current frame.
REQ-022 The SEQ, SHADOW, PM and RANGE fields SHALL be stored in ctrl but SHALL have no other effect.
REQ-023 An sclk fall while cs is high SHALL have no effect.

Reset
REQ-024 While rst is asserted, the block SHALL set: state IDLE; ctrl=12'h000 (ADD=0, two's complement); serial_out=0; serial_oe=0; frame_done=0; frame_abort=0; counter=0; rx=0; tx=0; all synchronizer flops to the idle pin levels (sclk=1, cs=1).
REQ-025 A reset mid-frame SHALL discard the frame with no frame_done or frame_abort pulse, and the block SHALL wait for the next cs falling edge after release.

Structure
REQ-026 Package ad79x8_pkg SHALL hold:
- FRAME_BITS=16;
- control field positions (WRITE=15, SEQ=14, ADD=12:10, PM=9:8, SHADOW=7, RANGE=5, CODING=4);
- the state enum {IDLE, SHIFT, HOLD}.
REQ-027 Sub-module sync_edge SHALL provide one 2-flop synchronizer plus rise/fall detect, with parameterized reset value, instantiated three times.

Verification
REQ-028 Reset, then frame 16'h9710 with ch_data[5]=12'hABC -> frame_done pulse and ctrl=12'h971; the next frame returns DOUT=16'h5ABC.
REQ-029 ctrl CODING=0 with ADD=5 and ch_data[5]=12'hABC -> DOUT=16'h52BC.
REQ-030 Frame with WRITE=0 (16'h1710) -> ctrl unchanged and frame_done pulses.
REQ-031 cs rises after 9 sclk edges -> frame_abort pulses, ctrl unchanged, serial_oe=0, and the next full frame works normally.
REQ-032 20 sclk edges in one frame -> a single frame_done, edges 17-20 ignored, serial_out=0.
REQ-033 rst asserted at edge 8 -> all outputs at reset values and no pulses; after release, a full frame yields DOUT=16'h0xxx from channel 0.
